// File: rtl/output_queue.sv
// Egress queue behind the output arbiter: tags granted FIFO words with their source index and
// buffers them in a circular queue. Optional statistics are enabled with OUTQ_STATS_EN.
module output_queue #(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned PTR_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_INPUTS-1:0]        fifo_rd_en,
  input  logic [NUM_INPUTS*DATA_W-1:0] fifo_rd_data,
  output logic                         outq_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [PTR_W-1:0]             out_src,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             occupancy,
  output logic                         proto_err
`ifdef OUTQ_STATS_EN
  ,
  output logic [31:0]                  stat_words,
  output logic [31:0]                  stat_stall
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_vld_q, pend_vld_d;
  logic [PTR_W-1:0] pend_idx_q, pend_idx_d;
  logic             proto_err_q, proto_err_d;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  mem_src  [DEPTH];

  logic             rd_any, rd_onehot, rd_accept;
  logic [PTR_W-1:0] rd_idx;
  logic [CNT_W:0]   credit_sum;
  logic             push, pop;

  assign rd_any    = |fifo_rd_en;
  assign rd_onehot = (fifo_rd_en & (fifo_rd_en - NUM_INPUTS'(1))) == '0;

  always_comb begin
    rd_idx = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (fifo_rd_en[i]) rd_idx = rd_idx | PTR_W'(i);
    end
  end

  // Credit counts the in-flight read so a granted word always has a free slot.
  assign credit_sum = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_vld_q};
  assign outq_ready = credit_sum < (CNT_W + 1)'(DEPTH);

  assign rd_accept = rd_any & rd_onehot & outq_ready;
  assign push      = pend_vld_q;
  assign out_valid = count_q != '0;
  assign pop       = out_valid & out_ready;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pend_vld_d  = rd_accept;
    pend_idx_d  = rd_accept ? rd_idx : pend_idx_q;
    proto_err_d = proto_err_q | (rd_any & ~(rd_onehot & outq_ready));
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pend_vld_q  <= 1'b0;
      pend_idx_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pend_vld_q  <= pend_vld_d;
      pend_idx_q  <= pend_idx_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage needs no reset; the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= fifo_rd_data[pend_idx_q*DATA_W +: DATA_W];
      mem_src[wr_ptr_q]  <= pend_idx_q;
    end
  end

  assign out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
  assign out_src   = out_valid ? mem_src[rd_ptr_q] : '0;
  assign occupancy = count_q;
  assign proto_err = proto_err_q;

`ifdef OUTQ_STATS_EN
  logic [31:0] stat_words_q, stat_words_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    if (push && (stat_words_q != 32'hFFFF_FFFF)) stat_words_d = stat_words_q + 32'd1;
    if (out_valid && !out_ready && (stat_stall_q != 32'hFFFF_FFFF)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
